debug_mode_ctrl: RTL and testbench
==================================

# debug_mode_ctrl

Top-level sequencer of the debugger unit. It decodes command bytes from the UART receiver and launches exactly one sub-controller at a time: program loader, continuous-run controller, or the single-step FSM. While a run or step mode is active, it gives that mode sole access to the shared register-dump sender and routes the sender's completion back to it. It also reports the active mode, per-command cycle count and rejected-command count to the host-visible status path.

## Interface
- CMD_LOAD, 8'h0A, command byte that starts program load
- CMD_RUN, 8'h0B, command byte that starts continuous run
- CMD_STEP, 8'h0C, command byte that enters step mode; must differ from the step-trigger byte 8'h0F
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_rx_data  in  8  received UART byte
- is_rx_done  in  1  one-cycle strobe: i_rx_data valid
- os_start_load / os_start_run / os_start_step  out  1  one-cycle start pulse to the matching sub-controller
- is_load_done / is_run_done / is_step_done  in  1  completion strobes from the sub-controllers
- is_send_req_run / is_send_req_step  in  1  send request from run / step controller
- os_start_send  out  1  start strobe to the shared sender
- is_done_send  in  1  sender completion strobe
- os_done_send_run / os_done_send_step  out  1  routed sender completion
- os_cmd_done  out  1  one-cycle pulse when a command finishes
- o_mode  out  2  0 none, 1 load, 2 run, 3 step
- o_loaded  out  1  a program has been loaded
- o_cmd_cycles  out  32  cycles spent in the current or last command
- o_err_count  out  8  rejected command bytes, saturating

## Operation
- States: IDLE, START_LOAD, WAIT_LOAD, START_RUN, WAIT_RUN, START_STEP, WAIT_STEP, FINISH.
- IDLE, on is_rx_done:
  - byte == CMD_LOAD → START_LOAD.
  - byte == CMD_RUN and o_loaded → START_RUN.
  - byte == CMD_STEP and o_loaded → START_STEP.
  - Any other byte, or run/step while not loaded → stay in IDLE and increment o_err_count, saturating at 8'hFF.
- START_x:
  - os_start_x = 1 for this single cycle.
  - o_mode set to x.
  - o_cmd_cycles cleared to 0.
  - Next state is WAIT_x, unconditionally.
- WAIT_x:
  - o_cmd_cycles increments by 1 each cycle, saturating at 32'hFFFFFFFF.
  - is_x_done → FINISH.
  - is_rx_done is ignored; bytes belong to the active sub-controller, e.g. 8'h0F step triggers.
- FINISH:
  - os_cmd_done = 1.
  - If o_mode == 1, set o_loaded = 1.
  - Next state is IDLE, with o_mode cleared to 0.
  - o_cmd_cycles holds its value until the next START.
- Strobes in inactive states: done strobes from a non-active sub-controller are ignored.
- Sender arbitration (combinational):
  - os_start_send = (o_mode==2 & is_send_req_run) | (o_mode==3 & is_send_req_step).
  - os_done_send_run = (o_mode==2) & is_done_send.
  - os_done_send_step = (o_mode==3) & is_done_send.
  - Requests from a non-active mode are dropped, not queued.
- o_loaded is never cleared except by reset. A new load keeps it at 1.
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - o_mode = 0, o_loaded = 0, o_cmd_cycles = 0, o_err_count = 0.
  - All strobes read 0 the following cycle.
  - Reset applies mid-command; sub-controllers are reset by the same rst.
- Unused state encodings → IDLE, with all outputs at their reset values.

## Timing
- Command accepted in cycle N (is_rx_done = 1 in IDLE) → os_start_x high in cycle N+1, WAIT_x from N+2.
- is_x_done in cycle M → os_cmd_done high in M+1, IDLE in M+2. A new command byte is accepted from M+2; a byte in M or M+1 is dropped without counting as an error.
- o_cmd_cycles equals the number of WAIT_x cycles, including the cycle in which is_x_done is sampled.
- Arbitration outputs have zero latency (same cycle as the request or done input).
- All registered outputs are Moore outputs of the state register; no output depends on i_rx_data combinationally.

## Test plan
- Load: reset, then rx 8'h0A → os_start_load pulse one cycle later, o_mode=1. is_load_done after 10 WAIT cycles → os_cmd_done, o_loaded=1, o_cmd_cycles=10, o_mode=0.
- Rejects: rx 8'h0B and 8'h0C before any load, then 8'h55 → no start pulses, o_err_count=3. Feed 260 invalid bytes → o_err_count saturates at 255.
- Step routing:
  - Load, then rx 8'h0C → os_start_step, o_mode=3.
  - rx 8'h0F during WAIT_STEP → o_err_count unchanged.
  - is_send_req_step → os_start_send the same cycle; is_done_send → os_done_send_step=1, os_done_send_run=0.
  - is_send_req_run in the same mode → os_start_send=0.
- Run, then a step command while running: rx 8'h0B, then rx 8'h0C during WAIT_RUN → ignored. is_run_done → FINISH, IDLE. rx 8'h0C then starts step normally.
- Edges: is_step_done asserted while in WAIT_RUN → no transition. rx byte in the FINISH cycle → dropped, o_err_count unchanged.
- Reset in WAIT_STEP: rst=0 for one cycle → next cycle o_mode=0, o_loaded=0, all strobes 0. rx 8'h0C then increments o_err_count.

Source files
------------

// File: rtl/debug_mode_ctrl.sv
// -----------------------------------------------------------------------------
// debug_mode_ctrl
//
// Top-level sequencer of the debugger unit. Decodes command bytes from the
// UART receiver and launches exactly one sub-controller at a time (program
// loader, continuous run, single step). While run or step is active, that mode
// owns the shared register-dump sender, and the sender's completion strobe is
// routed back to it. Also reports the active mode, the per-command cycle count
// and the number of rejected command bytes.
//
// Ports
//   clk, rst                         clock, synchronous active-low reset
//   i_rx_data, is_rx_done            received UART byte + valid strobe
//   os_start_load/run/step           one-cycle start pulse to a sub-controller
//   is_load_done/run_done/step_done  completion strobes from sub-controllers
//   is_send_req_run/step             sender requests from run / step
//   os_start_send, is_done_send      shared sender start / completion
//   os_done_send_run/step            sender completion routed to owner
//   os_cmd_done                      one-cycle pulse when a command finishes
//   o_mode                           0 none, 1 load, 2 run, 3 step
//   o_loaded                         a program has been loaded
//   o_cmd_cycles                     WAIT cycles of the current/last command
//   o_err_count                      rejected command bytes, saturating
// -----------------------------------------------------------------------------
module debug_mode_ctrl #(
  parameter logic [7:0] CMD_LOAD = 8'h0A,
  parameter logic [7:0] CMD_RUN  = 8'h0B,
  // Must differ from the step-trigger byte 8'h0F used inside step mode.
  parameter logic [7:0] CMD_STEP = 8'h0C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        is_rx_done,
  output logic        os_start_load,
  output logic        os_start_run,
  output logic        os_start_step,
  input  logic        is_load_done,
  input  logic        is_run_done,
  input  logic        is_step_done,
  input  logic        is_send_req_run,
  input  logic        is_send_req_step,
  output logic        os_start_send,
  input  logic        is_done_send,
  output logic        os_done_send_run,
  output logic        os_done_send_step,
  output logic        os_cmd_done,
  output logic [1:0]  o_mode,
  output logic        o_loaded,
  output logic [31:0] o_cmd_cycles,
  output logic [7:0]  o_err_count
);

  typedef enum logic [2:0] {
    IDLE, START_LOAD, WAIT_LOAD, START_RUN, WAIT_RUN, START_STEP, WAIT_STEP, FINISH
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0, MODE_LOAD = 2'd1, MODE_RUN = 2'd2, MODE_STEP = 2'd3
  } mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic        loaded_q, loaded_d;
  logic [31:0] cycles_q, cycles_d;
  logic [7:0]  err_q, err_d;
  logic        start_load_q, start_load_d;
  logic        start_run_q, start_run_d;
  logic        start_step_q, start_step_d;
  logic        cmd_done_q, cmd_done_d;

  logic [31:0] cycles_inc;
  assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    loaded_d     = loaded_q;
    cycles_d     = cycles_q;
    err_d        = err_q;
    start_load_d = 1'b0;
    start_run_d  = 1'b0;
    start_step_d = 1'b0;
    cmd_done_d   = 1'b0;

    // Next-state decision.
    unique case (state_q)
      IDLE: begin
        if (is_rx_done) begin
          if (i_rx_data == CMD_LOAD)                  state_d = START_LOAD;
          else if (i_rx_data == CMD_RUN  && loaded_q) state_d = START_RUN;
          else if (i_rx_data == CMD_STEP && loaded_q) state_d = START_STEP;
          else if (err_q != 8'hFF)                    err_d   = err_q + 8'd1;
        end
      end
      START_LOAD: state_d = WAIT_LOAD;
      START_RUN:  state_d = WAIT_RUN;
      START_STEP: state_d = WAIT_STEP;
      // Received bytes are ignored while waiting: they belong to the active
      // sub-controller (e.g. step triggers).
      WAIT_LOAD: begin
        cycles_d = cycles_inc;
        if (is_load_done) state_d = FINISH;
      end
      WAIT_RUN: begin
        cycles_d = cycles_inc;
        if (is_run_done) state_d = FINISH;
      end
      WAIT_STEP: begin
        cycles_d = cycles_inc;
        if (is_step_done) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: begin
        state_d  = IDLE;
        mode_d   = MODE_NONE;
        loaded_d = 1'b0;
        cycles_d = '0;
        err_d    = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each one is
    // a clean Moore output of the state it belongs to.
    case (state_d)
      START_LOAD: begin start_load_d = 1'b1; mode_d = MODE_LOAD; cycles_d = '0; end
      START_RUN:  begin start_run_d  = 1'b1; mode_d = MODE_RUN;  cycles_d = '0; end
      START_STEP: begin start_step_d = 1'b1; mode_d = MODE_STEP; cycles_d = '0; end
      FINISH: begin
        cmd_done_d = 1'b1;
        if (mode_q == MODE_LOAD) loaded_d = 1'b1;
      end
      IDLE:    mode_d = MODE_NONE;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_NONE;
      loaded_q     <= 1'b0;
      cycles_q     <= '0;
      err_q        <= '0;
      start_load_q <= 1'b0;
      start_run_q  <= 1'b0;
      start_step_q <= 1'b0;
      cmd_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      loaded_q     <= loaded_d;
      cycles_q     <= cycles_d;
      err_q        <= err_d;
      start_load_q <= start_load_d;
      start_run_q  <= start_run_d;
      start_step_q <= start_step_d;
      cmd_done_q   <= cmd_done_d;
    end
  end

  // Sender arbitration: only the active run/step mode reaches the sender;
  // requests from any other mode are dropped, not queued.
  assign os_start_send     = (mode_q == MODE_RUN  && is_send_req_run) ||
                             (mode_q == MODE_STEP && is_send_req_step);
  assign os_done_send_run  = (mode_q == MODE_RUN)  && is_done_send;
  assign os_done_send_step = (mode_q == MODE_STEP) && is_done_send;

  assign os_start_load = start_load_q;
  assign os_start_run  = start_run_q;
  assign os_start_step = start_step_q;
  assign os_cmd_done   = cmd_done_q;
  assign o_mode        = mode_q;
  assign o_loaded      = loaded_q;
  assign o_cmd_cycles  = cycles_q;
  assign o_err_count   = err_q;

endmodule

// File: tb/tb_debug_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_mode_ctrl
//
// Directed stimulus against debug_mode_ctrl. A command-level model tracks the
// accepted command by its start cycle and done cycle and derives every output
// from those cycle numbers; it is compared with the DUT on every falling edge.
// Literal checks at key points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_debug_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        is_rx_done = 1'b0;
  logic        os_start_load, os_start_run, os_start_step;
  logic        is_load_done = 1'b0, is_run_done = 1'b0, is_step_done = 1'b0;
  logic        is_send_req_run = 1'b0, is_send_req_step = 1'b0;
  logic        os_start_send;
  logic        is_done_send = 1'b0;
  logic        os_done_send_run, os_done_send_step;
  logic        os_cmd_done;
  logic [1:0]  o_mode;
  logic        o_loaded;
  logic [31:0] o_cmd_cycles;
  logic [7:0]  o_err_count;

  debug_mode_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_rx_data         (i_rx_data),
    .is_rx_done        (is_rx_done),
    .os_start_load     (os_start_load),
    .os_start_run      (os_start_run),
    .os_start_step     (os_start_step),
    .is_load_done      (is_load_done),
    .is_run_done       (is_run_done),
    .is_step_done      (is_step_done),
    .is_send_req_run   (is_send_req_run),
    .is_send_req_step  (is_send_req_step),
    .os_start_send     (os_start_send),
    .is_done_send      (is_done_send),
    .os_done_send_run  (os_done_send_run),
    .os_done_send_step (os_done_send_step),
    .os_cmd_done       (os_cmd_done),
    .o_mode            (o_mode),
    .o_loaded          (o_loaded),
    .o_cmd_cycles      (o_cmd_cycles),
    .o_err_count       (o_err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Command-level model. A command accepted in cycle N starts in t_start=N+1;
  // its done strobe is seen in t_done; FINISH is t_done+1; idle from t_done+2.
  // ---------------------------------------------------------------------------
  int cyc      = 0;
  bit accepted = 0;
  int cmd      = 0;
  int t_start  = 0;
  int t_done   = -1;
  bit m_loaded = 0;
  int m_errs   = 0;
  int m_hold   = 0;

  always @(negedge clk) begin
    bit in_cmd, in_wait, done_in;
    int e_mode, e_cycles;

    in_cmd  = accepted && cyc >= t_start && (t_done < 0 || cyc <= t_done + 1);
    in_wait = in_cmd && cyc > t_start && (t_done < 0 || cyc <= t_done);
    e_mode  = in_cmd ? cmd : 0;
    if (!in_cmd)             e_cycles = m_hold;
    else if (cyc == t_start) e_cycles = 0;
    else if (in_wait)        e_cycles = cyc - t_start - 1;
    else                     e_cycles = t_done - t_start;

    check("mode",       32'(o_mode),        32'(e_mode));
    check("loaded",     32'(o_loaded),      32'(m_loaded));
    check("err_count",  32'(o_err_count),   32'(m_errs));
    check("cmd_cycles", o_cmd_cycles,       32'(e_cycles));
    check("start_load", 32'(os_start_load), 32'(in_cmd && cyc == t_start && cmd == 1));
    check("start_run",  32'(os_start_run),  32'(in_cmd && cyc == t_start && cmd == 2));
    check("start_step", 32'(os_start_step), 32'(in_cmd && cyc == t_start && cmd == 3));
    check("cmd_done",   32'(os_cmd_done),   32'(t_done >= 0 && cyc == t_done + 1 && accepted));
    check("start_send", 32'(os_start_send),
          32'((e_mode == 2 && is_send_req_run) || (e_mode == 3 && is_send_req_step)));
    check("done_send_run",  32'(os_done_send_run),  32'(e_mode == 2 && is_done_send));
    check("done_send_step", 32'(os_done_send_step), 32'(e_mode == 3 && is_done_send));

    // Advance the model with this cycle's inputs.
    if (!rst) begin
      accepted = 0; t_done = -1; m_loaded = 0; m_errs = 0; m_hold = 0;
    end else if (!accepted) begin
      if (is_rx_done) begin
        if (i_rx_data == 8'h0A)                   begin accepted = 1; cmd = 1; end
        else if (i_rx_data == 8'h0B && m_loaded)  begin accepted = 1; cmd = 2; end
        else if (i_rx_data == 8'h0C && m_loaded)  begin accepted = 1; cmd = 3; end
        else if (m_errs < 255)                    m_errs++;
        if (accepted) begin t_start = cyc + 1; t_done = -1; end
      end
    end else begin
      done_in = (cmd == 1 && is_load_done) || (cmd == 2 && is_run_done) ||
                (cmd == 3 && is_step_done);
      if (in_wait && t_done < 0 && done_in) begin
        t_done = cyc;
        if (cmd == 1) m_loaded = 1;
      end else if (t_done >= 0 && cyc == t_done + 1) begin
        accepted = 0;
        m_hold   = t_done - t_start;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    is_rx_done = 0; i_rx_data = '0;
    is_load_done = 0; is_run_done = 0; is_step_done = 0;
    is_send_req_run = 0; is_send_req_step = 0; is_done_send = 0;
  endtask

  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    is_rx_done = 1;
    step();
  endtask

  initial begin
    repeat (2) step();
    rst = 1;
    @(negedge clk);
    check("lit_reset_mode",   32'(o_mode),      32'd0);
    check("lit_reset_loaded", 32'(o_loaded),    32'd0);
    check("lit_reset_err",    32'(o_err_count), 32'd0);

    // Rejects before any program is loaded.
    rx(8'h0B); rx(8'h0C); rx(8'h55);
    @(negedge clk);
    check("lit_rejects_err",  32'(o_err_count),   32'd3);
    check("lit_rejects_mode", 32'(o_mode),        32'd0);

    // Load with done after 10 WAIT cycles.
    rx(8'h0A);
    @(negedge clk);
    check("lit_load_pulse", 32'(os_start_load), 32'd1);
    check("lit_load_mode",  32'(o_mode),        32'd1);
    step();
    repeat (9) step();
    is_load_done = 1;
    step();
    @(negedge clk);
    check("lit_load_cmd_done", 32'(os_cmd_done), 32'd1);
    check("lit_load_cycles",   o_cmd_cycles,     32'd10);
    check("lit_load_loaded",   32'(o_loaded),    32'd1);
    step();
    @(negedge clk);
    check("lit_load_idle_mode", 32'(o_mode),   32'd0);
    check("lit_load_hold",      o_cmd_cycles,  32'd10);

    // Step routing.
    rx(8'h0C);
    @(negedge clk);
    check("lit_step_pulse", 32'(os_start_step), 32'd1);
    check("lit_step_mode",  32'(o_mode),        32'd3);
    step();
    rx(8'h0F);
    @(negedge clk);
    check("lit_step_trigger_err", 32'(o_err_count), 32'd3);
    is_send_req_step = 1;
    @(negedge clk);
    check("lit_step_send", 32'(os_start_send), 32'd1);
    step();
    is_done_send = 1;
    @(negedge clk);
    check("lit_step_done_step", 32'(os_done_send_step), 32'd1);
    check("lit_step_done_run",  32'(os_done_send_run),  32'd0);
    step();
    is_send_req_run = 1;
    @(negedge clk);
    check("lit_step_req_run_dropped", 32'(os_start_send), 32'd0);
    step();
    is_step_done = 1;
    step(); step();

    // Run; step command and foreign done strobe while running are ignored.
    rx(8'h0B);
    step();
    rx(8'h0C);
    is_step_done = 1;
    step();
    is_load_done = 1;
    step();
    @(negedge clk);
    check("lit_run_mode", 32'(o_mode), 32'd2);
    is_run_done = 1; i_rx_data = 8'h55; is_rx_done = 1;
    step();
    i_rx_data = 8'h77; is_rx_done = 1;
    @(negedge clk);
    check("lit_run_finish", 32'(os_cmd_done), 32'd1);
    step();
    @(negedge clk);
    check("lit_run_dropped_err", 32'(o_err_count), 32'd3);
    rx(8'h0C);
    @(negedge clk);
    check("lit_step_after_run", 32'(os_start_step), 32'd1);
    step(); step();
    is_step_done = 1;
    step(); step();

    // Reset in WAIT_STEP.
    rx(8'h0C);
    step(); step();
    rst = 0;
    step();
    rst = 1;
    @(negedge clk);
    check("lit_rst_mode",     32'(o_mode),        32'd0);
    check("lit_rst_loaded",   32'(o_loaded),      32'd0);
    check("lit_rst_cmd_done", 32'(os_cmd_done),   32'd0);
    rx(8'h0C);
    @(negedge clk);
    check("lit_rst_err",        32'(o_err_count),   32'd1);
    check("lit_rst_no_step",    32'(os_start_step), 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) rx(i[0] ? 8'h55 : 8'hAA);
    @(negedge clk);
    check("lit_err_saturate", 32'(o_err_count), 32'd255);

    repeat (2) step();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
